if_id_register: RTL and testbench

- IF/ID pipeline register between the instruction fetch stage and the decode stage.
- Captures each fetched instruction, its incremented PC and its halt flag on every clock edge.
- Holds its contents on a stall and inserts a bubble on a flush (control-flow redirect).
- Tracks a halt that has reached decode so that nothing behind it is admitted until a flush clears it.

---
 rtl/if_id_register_pkg.sv | 33 +++
 rtl/if_id_register_sat_counter.sv | 33 +++
 rtl/if_id_register.sv | 78 +++++++
 tb/tb_if_id_register.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/if_id_register_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
package if_id_register_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OPC_W  = 4;

  localparam logic [DATA_W-1:0] NOP_INSTR_DEF = 16'h0000;
  localparam logic [OPC_W-1:0]  HALT_OPCODE   = 4'hF;

  typedef enum logic {
    RUN       = 1'b0,
    HALT_HELD = 1'b1
  } state_e;

  // Contents of the IF/ID latch as seen by decode.
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] next_pc;
    logic              hlt;
    logic              valid;
  } ifid_payload_t;

  // Non-architectural slot: hlt is forced low so a bubble never signals halt.
  function automatic ifid_payload_t bubble(input logic [DATA_W-1:0] nop);
    ifid_payload_t p;
    p.instr   = nop;
    p.next_pc = '0;
    p.hlt     = 1'b0;
    p.valid   = 1'b0;
    return p;
  endfunction

endpackage

// File: rtl/if_id_register_sat_counter.sv
// Enable-driven up-counter that sticks at all-ones, async active-low clear.
module if_id_register_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Increment when enabled unless already saturated.
  always_comb begin
    count_d = count_q;
    if (en && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_id_register.sv
// IF/ID pipeline register with stall hold, flush bubble and halt tracking.
module if_id_register
  import if_id_register_pkg::*;
#(
  parameter logic [DATA_W-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [DATA_W-1:0] Instruction_in,
  input  logic [DATA_W-1:0] NextPC_in,
  input  logic              hlt_in,
  output logic [DATA_W-1:0] Instruction_out,
  output logic [DATA_W-1:0] NextPC_out,
  output logic              hlt_out,
  output logic              Valid_out,
  output logic              Halted,
  output logic [CNT_W-1:0]  StallCount
);

  state_e        state_q;
  state_e        state_d;
  ifid_payload_t payload_q;
  ifid_payload_t payload_d;
  logic          stall_cnt_en_c;

  // Next payload and state; priority is flush, stall, halt hold, load.
  always_comb begin
    state_d        = state_q;
    payload_d      = payload_q;
    stall_cnt_en_c = 1'b0;
    if (Flush) begin
      payload_d = bubble(NOP_INSTR);
      state_d   = RUN;
    end else if (Stall) begin
      stall_cnt_en_c = 1'b1;
    end else if (state_q == RUN) begin
      payload_d.instr   = Instruction_in;
      payload_d.next_pc = NextPC_in;
      payload_d.hlt     = hlt_in;
      payload_d.valid   = 1'b1;
      if (hlt_in) begin
        state_d = HALT_HELD;
      end
    end
  end

  // Payload and FSM state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      payload_q <= bubble(NOP_INSTR);
      state_q   <= RUN;
    end else begin
      payload_q <= payload_d;
      state_q   <= state_d;
    end
  end

  // Cycles in which a stall (not overridden by flush) held the register.
  if_id_register_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (stall_cnt_en_c),
    .count (StallCount)
  );

  // hlt is only ever stored alongside valid=1, so it is already qualified.
  assign Instruction_out = payload_q.instr;
  assign NextPC_out      = payload_q.next_pc;
  assign hlt_out         = payload_q.hlt;
  assign Valid_out       = payload_q.valid;
  assign Halted          = (state_q == HALT_HELD);

endmodule

// File: tb/tb_if_id_register.sv
// Randomized self-checking bench for if_id_register against a behavioural model.
module tb_if_id_register;

  localparam int unsigned CW  = 4;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          Stall;
  logic          Flush;
  logic [15:0]   Instruction_in;
  logic [15:0]   NextPC_in;
  logic          hlt_in;
  logic [15:0]   Instruction_out;
  logic [15:0]   NextPC_out;
  logic          hlt_out;
  logic          Valid_out;
  logic          Halted;
  logic [CW-1:0] StallCount;

  int total;
  int bad;

  // Reference view of what decode should see.
  int m_instr, m_pc, m_hlt, m_valid, m_halted, m_cnt;

  if_id_register #(.NOP_INSTR(16'h0000), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .Stall           (Stall),
    .Flush           (Flush),
    .Instruction_in  (Instruction_in),
    .NextPC_in       (NextPC_in),
    .hlt_in          (hlt_in),
    .Instruction_out (Instruction_out),
    .NextPC_out      (NextPC_out),
    .hlt_out         (hlt_out),
    .Valid_out       (Valid_out),
    .Halted          (Halted),
    .StallCount      (StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".instr"},  32'(Instruction_out), 32'(m_instr));
    chk({tag, ".pc"},     32'(NextPC_out),      32'(m_pc));
    chk({tag, ".hlt"},    32'(hlt_out),         32'(m_hlt));
    chk({tag, ".valid"},  32'(Valid_out),       32'(m_valid));
    chk({tag, ".halted"}, 32'(Halted),          32'(m_halted));
    chk({tag, ".cnt"},    32'(StallCount),      32'(m_cnt));
  endtask

  task automatic model_reset();
    m_instr = 0; m_pc = 0; m_hlt = 0; m_valid = 0; m_halted = 0; m_cnt = 0;
  endtask

  // Apply one cycle of inputs, advance the model by the priority rules, check.
  task automatic cycle(input string tag, input logic st, input logic fl,
                       input logic [15:0] ins, input logic [15:0] pc, input logic h);
    Stall = st; Flush = fl; Instruction_in = ins; NextPC_in = pc; hlt_in = h;
    @(posedge clk);
    if (fl) begin
      m_instr = 0; m_pc = 0; m_hlt = 0; m_valid = 0; m_halted = 0;
    end else if (st) begin
      m_cnt = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
    end else if (m_halted == 0) begin
      m_instr = int'(ins); m_pc = int'(pc); m_hlt = int'(h); m_valid = 1;
      m_halted = int'(h);
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
    Instruction_in = 16'h0; NextPC_in = 16'h0; hlt_in = 1'b0;
    model_reset();
    #12;
    chk_all("reset");
    rst = 1'b1;

    // Normal flow
    cycle("load1", 1'b0, 1'b0, 16'hA001, 16'h0002, 1'b0);
    cycle("load2", 1'b0, 1'b0, 16'hB002, 16'h0004, 1'b0);

    // Async reset mid-cycle with data loaded
    cycle("pre_rst", 1'b0, 1'b0, 16'h1234, 16'h0010, 1'b0);
    cycle("stall_pre_rst", 1'b1, 1'b0, 16'h5555, 16'h0012, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    #2;
    rst = 1'b1;

    // Stall holds while inputs change
    cycle("st_load", 1'b0, 1'b0, 16'hA001, 16'h0002, 1'b0);
    cycle("st1", 1'b1, 1'b0, 16'hC003, 16'h0006, 1'b0);
    cycle("st2", 1'b1, 1'b0, 16'hC004, 16'h0008, 1'b1);
    cycle("st3", 1'b1, 1'b0, 16'hC005, 16'h000A, 1'b0);
    chk("st3.cnt_is_3", 32'(StallCount), 32'd3);

    // Flush beats stall, counter unchanged
    cycle("flush_stall", 1'b1, 1'b1, 16'hD006, 16'h000C, 1'b0);
    chk("flush_stall.cnt_is_3", 32'(StallCount), 32'd3);

    // Halt held, then squashed by flush
    cycle("halt_in", 1'b0, 1'b0, 16'hF000, 16'h0020, 1'b1);
    cycle("halt_hold", 1'b0, 1'b0, 16'h1111, 16'h0022, 1'b0);
    cycle("halt_stall", 1'b1, 1'b0, 16'h1112, 16'h0024, 1'b0);
    cycle("halt_flush", 1'b0, 1'b1, 16'h1113, 16'h0026, 1'b0);
    cycle("after_halt", 1'b0, 1'b0, 16'h2222, 16'h0028, 1'b0);

    // Saturation
    for (int i = 0; i < 20; i++) cycle("sat", 1'b1, 1'b0, 16'(i), 16'(2 * i), 1'b0);
    chk("sat.cnt_max", 32'(StallCount), 32'hF);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0),
            16'($urandom),
            16'($urandom),
            ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
